lcd_bus_driver: RTL and testbench

Responder side of the LCD start/instruction/done handshake. It accepts one 9-bit LCD instruction per request and drives the character-LCD pin bus with the required setup, enable-pulse and hold timing. It then waits a fixed execution delay and pulses done. It sits between the message-sequencing FSM in each experiment top level and the board's LCD pins.

---
 rtl/lcd_bus_driver_pkg.sv | 26 ++
 rtl/lcd_bus_driver_if.sv | 29 ++
 rtl/lcd_bus_driver.sv | 116 +++++++++++
 tb/tb_lcd_bus_driver.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/lcd_bus_driver_pkg.sv
// Shared types and instruction constants for the character-LCD bus driver.
package lcd_pkg;

  // Bus-cycle phases of one LCD write.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ENABLE = 3'd2,
    S_HOLD   = 3'd3,
    S_DELAY  = 3'd4
  } lcd_state_t;

  // Bit 8 of an instruction selects RS (0 command, 1 data).
  localparam int unsigned LCD_RS_BIT = 8;

  localparam logic [8:0] LCD_CMD_FUNCTION_SET = 9'h038;
  localparam logic [8:0] LCD_CMD_DISPLAY_ON   = 9'h00C;
  localparam logic [8:0] LCD_CMD_CLEAR        = 9'h001;
  localparam logic [8:0] LCD_CMD_ENTRY_MODE   = 9'h006;
  localparam logic [8:0] LCD_CMD_LINE1        = 9'h080;
  localparam logic [8:0] LCD_CMD_LINE2        = 9'h0C0;

  // Prepend to a character byte to form a data-write instruction.
  localparam logic LCD_DATA_PREFIX = 1'b1;

endpackage

// File: rtl/lcd_bus_driver_if.sv
// Start/instruction/done handshake plus the LCD pin bus.
interface lcd_bus_driver_if;

  logic       LCD_start;
  logic [8:0] LCD_instruction;
  logic       LCD_done;
  logic       LCD_busy;
  logic       LCD_power;
  logic       LCD_back_light;
  logic       LCD_read_write;
  logic       LCD_enable;
  logic       LCD_command_data_select;
  logic [7:0] LCD_data_io;

  // Requester side: issues instructions and watches the pins.
  modport master (
    output LCD_start, LCD_instruction,
    input  LCD_done, LCD_busy, LCD_power, LCD_back_light, LCD_read_write,
    input  LCD_enable, LCD_command_data_select, LCD_data_io
  );

  // Responder side: the bus driver.
  modport slave (
    input  LCD_start, LCD_instruction,
    output LCD_done, LCD_busy, LCD_power, LCD_back_light, LCD_read_write,
    output LCD_enable, LCD_command_data_select, LCD_data_io
  );

endinterface

// File: rtl/lcd_bus_driver.sv
// Accepts one 9-bit LCD instruction per start strobe, drives RS/data with
// setup, enable-pulse and hold timing, waits the execution delay, pulses done.
module lcd_bus_driver
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES        = 4,
  parameter int unsigned ENABLE_CYCLES       = 16,
  parameter int unsigned HOLD_CYCLES         = 4,
  parameter logic [17:0] MAX_LCD_delay_count = 18'h3FFFE
) (
  input  logic               Clock_50,
  input  logic               Resetn,
  lcd_bus_driver_if.slave    bus
);

  // Terminal counts of each timed phase (counter runs 0..N-1).
  localparam logic [17:0] SetupLast  = 18'(SETUP_CYCLES - 1);
  localparam logic [17:0] EnableLast = 18'(ENABLE_CYCLES - 1);
  localparam logic [17:0] HoldLast   = 18'(HOLD_CYCLES - 1);

  lcd_state_t  r_state, w_state;
  logic [17:0] r_cnt, w_cnt;
  logic        r_enable, w_enable;
  logic        r_done, w_done;
  logic        r_busy, w_busy;
  logic        r_rs, w_rs;
  logic [7:0]  r_data, w_data;

  // State, phase counter and registered pin outputs.
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_enable <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_rs     <= 1'b0;
      r_data   <= 8'h00;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_enable <= w_enable;
      r_done   <= w_done;
      r_busy   <= w_busy;
      r_rs     <= w_rs;
      r_data   <= w_data;
    end
  end

  // Next-state logic; the counter restarts from zero on every state entry.
  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt + 18'd1;
    w_enable = r_enable;
    w_done   = 1'b0;
    w_busy   = r_busy;
    w_rs     = r_rs;
    w_data   = r_data;
    case (r_state)
      S_IDLE: begin
        w_cnt    = '0;
        w_enable = 1'b0;
        if (bus.LCD_start) begin
          w_state = S_SETUP;
          w_rs    = bus.LCD_instruction[LCD_RS_BIT];
          w_data  = bus.LCD_instruction[7:0];
          w_busy  = 1'b1;
        end
      end
      S_SETUP: begin
        if (r_cnt == SetupLast) begin
          w_state  = S_ENABLE;
          w_cnt    = '0;
          w_enable = 1'b1;
        end
      end
      S_ENABLE: begin
        if (r_cnt == EnableLast) begin
          w_state  = S_HOLD;
          w_cnt    = '0;
          w_enable = 1'b0;
        end
      end
      S_HOLD: begin
        if (r_cnt == HoldLast) begin
          w_state = S_DELAY;
          w_cnt   = '0;
        end
      end
      S_DELAY: begin
        if (r_cnt == MAX_LCD_delay_count) begin
          w_state = S_IDLE;
          w_cnt   = '0;
          w_done  = 1'b1;
          w_busy  = 1'b0;
        end
      end
      default: begin
        w_state  = S_IDLE;
        w_cnt    = '0;
        w_enable = 1'b0;
        w_busy   = 1'b0;
      end
    endcase
  end

  assign bus.LCD_done                = r_done;
  assign bus.LCD_busy                = r_busy;
  assign bus.LCD_enable              = r_enable;
  assign bus.LCD_command_data_select = r_rs;
  assign bus.LCD_data_io             = r_data;
  assign bus.LCD_power               = 1'b1;
  assign bus.LCD_back_light          = 1'b1;
  assign bus.LCD_read_write          = 1'b0;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Directed bench for lcd_bus_driver with short timing (17-cycle latency).
module tb_lcd_bus_driver;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  lcd_bus_driver_if bus();

  lcd_bus_driver #(
    .SETUP_CYCLES        (2),
    .ENABLE_CYCLES       (3),
    .HOLD_CYCLES         (2),
    .MAX_LCD_delay_count (18'd9)
  ) u_dut (
    .Clock_50 (clk),
    .Resetn   (rstn),
    .bus      (bus)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bus.LCD_enable !== 1'b0) begin errors++; $display("FAIL reset_enable got %b want 0", bus.LCD_enable); end
    checks++; if (bus.LCD_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.LCD_done); end
    checks++; if (bus.LCD_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.LCD_busy); end
    checks++; if (bus.LCD_data_io !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", bus.LCD_data_io); end
    checks++; if (bus.LCD_command_data_select !== 1'b0) begin errors++; $display("FAIL reset_rs got %b want 0", bus.LCD_command_data_select); end
    checks++; if (bus.LCD_power !== 1'b1) begin errors++; $display("FAIL reset_power got %b want 1", bus.LCD_power); end
    checks++; if (bus.LCD_back_light !== 1'b1) begin errors++; $display("FAIL reset_backlight got %b want 1", bus.LCD_back_light); end
    checks++; if (bus.LCD_read_write !== 1'b0) begin errors++; $display("FAIL reset_rw got %b want 0", bus.LCD_read_write); end
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_single_command();
    bus.LCD_instruction = 9'h038;
    bus.LCD_start = 1'b1;
    tick();  // edge E0
    bus.LCD_start = 1'b0;
    bus.LCD_instruction = 9'h1FF;  // must not disturb the latched bus
    checks++; if (bus.LCD_busy !== 1'b1) begin errors++; $display("FAIL single_busy_accept got %b want 1", bus.LCD_busy); end
    checks++; if (bus.LCD_data_io !== 8'h38) begin errors++; $display("FAIL single_data_accept got %h want 38", bus.LCD_data_io); end
    checks++; if (bus.LCD_command_data_select !== 1'b0) begin errors++; $display("FAIL single_rs got %b want 0", bus.LCD_command_data_select); end
    for (int k = 1; k <= 17; k++) begin
      tick();
      checks++; if (bus.LCD_enable !== (k >= 2 && k <= 4)) begin errors++; $display("FAIL single_enable k=%0d got %b want %b", k, bus.LCD_enable, (k >= 2 && k <= 4)); end
      checks++; if (bus.LCD_done !== (k == 17)) begin errors++; $display("FAIL single_done k=%0d got %b want %b", k, bus.LCD_done, (k == 17)); end
      checks++; if (bus.LCD_busy !== (k != 17)) begin errors++; $display("FAIL single_busy k=%0d got %b want %b", k, bus.LCD_busy, (k != 17)); end
      checks++; if (bus.LCD_data_io !== 8'h38) begin errors++; $display("FAIL single_data k=%0d got %h want 38", k, bus.LCD_data_io); end
    end
    tick();
    checks++; if (bus.LCD_done !== 1'b0) begin errors++; $display("FAIL single_done_after got %b want 0", bus.LCD_done); end
  endtask

  task automatic test_back_to_back();
    bus.LCD_instruction = 9'h138;
    bus.LCD_start = 1'b1;
    tick();
    bus.LCD_start = 1'b0;
    checks++; if (bus.LCD_command_data_select !== 1'b1) begin errors++; $display("FAIL b2b_rs1 got %b want 1", bus.LCD_command_data_select); end
    for (int k = 1; k <= 17; k++) begin
      tick();
      checks++; if (bus.LCD_data_io !== 8'h38) begin errors++; $display("FAIL b2b_data1 k=%0d got %h want 38", k, bus.LCD_data_io); end
      checks++; if (bus.LCD_done !== (k == 17)) begin errors++; $display("FAIL b2b_done1 k=%0d got %b want %b", k, bus.LCD_done, (k == 17)); end
    end
    // Second request issued in the done cycle.
    bus.LCD_instruction = 9'h130;
    bus.LCD_start = 1'b1;
    tick();
    bus.LCD_start = 1'b0;
    checks++; if (bus.LCD_data_io !== 8'h30) begin errors++; $display("FAIL b2b_data2_accept got %h want 30", bus.LCD_data_io); end
    checks++; if (bus.LCD_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy2 got %b want 1", bus.LCD_busy); end
    checks++; if (bus.LCD_command_data_select !== 1'b1) begin errors++; $display("FAIL b2b_rs2 got %b want 1", bus.LCD_command_data_select); end
    for (int k = 1; k <= 17; k++) begin
      tick();
      checks++; if (bus.LCD_enable !== (k >= 2 && k <= 4)) begin errors++; $display("FAIL b2b_enable2 k=%0d got %b want %b", k, bus.LCD_enable, (k >= 2 && k <= 4)); end
      checks++; if (bus.LCD_done !== (k == 17)) begin errors++; $display("FAIL b2b_done2 k=%0d got %b want %b", k, bus.LCD_done, (k == 17)); end
    end
    tick();
  endtask

  task automatic test_start_while_busy();
    int dones = 0;
    int done_k = -1;
    bus.LCD_instruction = 9'h0C0;
    bus.LCD_start = 1'b1;
    tick();
    bus.LCD_start = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (bus.LCD_done === 1'b1) begin dones++; done_k = k; end
      checks++; if (bus.LCD_data_io !== 8'hC0) begin errors++; $display("FAIL busy_data k=%0d got %h want c0", k, bus.LCD_data_io); end
      if (k == 4) begin bus.LCD_instruction = 9'h001; bus.LCD_start = 1'b1; end
      if (k == 5) bus.LCD_start = 1'b0;
    end
    checks++; if (dones !== 1) begin errors++; $display("FAIL busy_done_count got %0d want 1", dones); end
    checks++; if (done_k !== 17) begin errors++; $display("FAIL busy_done_cycle got %0d want 17", done_k); end
    checks++; if (bus.LCD_busy !== 1'b0) begin errors++; $display("FAIL busy_final got %b want 0", bus.LCD_busy); end
  endtask

  task automatic test_reset_mid_transfer();
    int dones = 0;
    int k = 0;
    bus.LCD_instruction = 9'h038;
    bus.LCD_start = 1'b1;
    tick();
    bus.LCD_start = 1'b0;
    tick(); tick(); tick();
    checks++; if (bus.LCD_enable !== 1'b1) begin errors++; $display("FAIL midrst_enable_before got %b want 1", bus.LCD_enable); end
    #2 rstn = 1'b0;
    #1;
    checks++; if (bus.LCD_enable !== 1'b0) begin errors++; $display("FAIL midrst_enable_async got %b want 0", bus.LCD_enable); end
    checks++; if (bus.LCD_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", bus.LCD_busy); end
    checks++; if (bus.LCD_data_io !== 8'h00) begin errors++; $display("FAIL midrst_data got %h want 00", bus.LCD_data_io); end
    #2 rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.LCD_done === 1'b1) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL midrst_no_done got %0d want 0", dones); end
    bus.LCD_instruction = 9'h038;
    bus.LCD_start = 1'b1;
    tick();
    bus.LCD_start = 1'b0;
    while (k < 40 && bus.LCD_done !== 1'b1) begin
      tick();
      k++;
    end
    checks++; if (k !== 17) begin errors++; $display("FAIL midrst_restart_latency got %0d want 17", k); end
    tick();
  endtask

  task automatic test_init_sequence();
    logic [8:0] seq [4];
    int total_dones = 0;
    seq[0] = 9'h038; seq[1] = 9'h00C; seq[2] = 9'h001; seq[3] = 9'h006;
    for (int n = 0; n < 4; n++) begin
      int   k = 0;
      int   rises = 0;
      logic prev_en = 1'b0;
      logic seen = 1'b0;
      bus.LCD_instruction = seq[n];
      bus.LCD_start = 1'b1;
      tick();
      bus.LCD_start = 1'b0;
      while (!seen && k < 40) begin
        tick();
        k++;
        if (bus.LCD_enable === 1'b1 && !prev_en) begin
          rises++;
          checks++; if (bus.LCD_data_io !== seq[n][7:0]) begin errors++; $display("FAIL init_data n=%0d got %h want %h", n, bus.LCD_data_io, seq[n][7:0]); end
        end
        prev_en = bus.LCD_enable;
        if (bus.LCD_done === 1'b1) begin seen = 1'b1; total_dones++; end
      end
      checks++; if (!seen || k != 17) begin errors++; $display("FAIL init_latency n=%0d got %0d want 17", n, k); end
      checks++; if (rises !== 1) begin errors++; $display("FAIL init_enable_pulses n=%0d got %0d want 1", n, rises); end
    end
    checks++; if (total_dones !== 4) begin errors++; $display("FAIL init_done_total got %0d want 4", total_dones); end
  endtask

  initial begin
    bus.LCD_start = 1'b0;
    bus.LCD_instruction = 9'h000;
    test_reset();
    test_single_command();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid_transfer();
    test_init_sequence();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
